// File: rtl/square_mover.sv
// square_mover: per-frame square motion with edge bounce and a registered in-square pixel flag
module square_mover #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int Q_SIZE = 200
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       speed,
  output logic [CORDW-1:0] qx,
  output logic [CORDW-1:0] qy,
  output logic             dx,
  output logic             dy,
  output logic             square,
  output logic             busy,
  output logic             bounce_x,
  output logic             bounce_y
);
  localparam logic [CORDW:0]   X_MAX = (CORDW+1)'(H_RES - Q_SIZE);
  localparam logic [CORDW:0]   Y_MAX = (CORDW+1)'(V_RES - Q_SIZE);
  localparam logic [CORDW:0]   QS    = (CORDW+1)'(Q_SIZE);
  localparam logic [CORDW-1:0] QX0   = CORDW'((H_RES - Q_SIZE) / 2);
  localparam logic [CORDW-1:0] QY0   = CORDW'((V_RES - Q_SIZE) / 2);
  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;
  state_t state;
  logic step_pend;
  logic [3:0] spd;
  logic trig, dir, hit;
  logic [CORDW:0] pos, lim, sp, sum, nxt, sxe, sye, qxe, qye;
  assign trig = sx == '0 && sy == CORDW'(V_RES);
  // one shared adder/comparator serves whichever axis the FSM is moving
  assign pos  = {1'b0, state == MOVE_X ? qx : qy};
  assign dir  = state == MOVE_X ? dx : dy;
  assign lim  = state == MOVE_X ? X_MAX : Y_MAX;
  assign sp   = (CORDW+1)'(spd);
  assign sum  = pos + sp;
  assign hit  = spd != '0 && (dir ? sum >= lim : pos <= sp);
  assign nxt  = hit ? (dir ? lim : '0) : (dir ? sum : pos - sp);
  assign sxe  = {1'b0, sx};
  assign sye  = {1'b0, sy};
  assign qxe  = {1'b0, qx};
  assign qye  = {1'b0, qy};
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state     <= IDLE;
      qx        <= QX0;
      qy        <= QY0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      spd       <= '0;
      step_pend <= 1'b0;
      square    <= 1'b0;
      busy      <= 1'b0;
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
    end else begin
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
      square    <= sxe >= qxe && sxe < qxe + QS && sye >= qye && sye < qye + QS;
      // a step coincident with the consuming trigger survives to the next frame
      step_pend <= run ? 1'b0 : (trig && state == IDLE && step_pend) ? step : (step_pend | step);
      case (state)
        IDLE: if (trig && (run || step_pend)) begin
          state <= MOVE_X;
          busy  <= 1'b1;
          spd   <= speed;
        end
        MOVE_X: begin
          qx       <= nxt[CORDW-1:0];
          dx       <= hit ? ~dx : dx;
          bounce_x <= hit;
          state    <= MOVE_Y;
        end
        MOVE_Y: begin
          qy       <= nxt[CORDW-1:0];
          dy       <= hit ? ~dy : dy;
          bounce_y <= hit;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_square_mover.sv
// tb_square_mover: scoreboard bench; moves are queued by the driver and checked when busy falls
module tb_square_mover;
  logic clk = 0, rst = 0, run = 0, step = 0;
  logic [9:0] sx = 10'd1, sy = 10'd0;
  logic [3:0] speed = 4'd0;
  logic [9:0] qx, qy;
  logic dx, dy, square, busy, bounce_x, bounce_y;
  typedef struct {int qx; int qy; int dx; int dy; int bx; int by;} exp_t;
  exp_t exp_q[$];
  bit sq_q[$];
  bit sq_v = 0, sq_vd = 0;
  int total = 0, bad = 0;
  int mqx, mqy, mdx, mdy;
  bit pend;
  int bcnt = 0, bxc = 0, byc = 0;
  bit bprev = 0;
  square_mover dut (
    .clk_pix(clk), .rst_pix(rst), .sx(sx), .sy(sy), .run(run), .step(step), .speed(speed),
    .qx(qx), .qy(qy), .dx(dx), .dy(dy), .square(square), .busy(busy),
    .bounce_x(bounce_x), .bounce_y(bounce_y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  always @(posedge clk) sq_vd <= sq_v;
  always @(negedge clk) begin
    exp_t e;
    if (sq_vd) begin
      if (sq_q.size() == 0) chk("square_queue_empty", 1, 0);
      else chk("square", 32'(square), 32'(sq_q.pop_front()));
    end
    if (rst) begin
      bcnt = 0; bxc = 0; byc = 0; bprev = 0;
    end else begin
      if (busy) begin
        bcnt++;
        if (bcnt == 10) chk("busy_stuck", 32'(busy), 0);
      end
      bxc += int'(bounce_x);
      byc += int'(bounce_y);
      if (!busy && bprev) begin
        if (exp_q.size() == 0) chk("unexpected_move", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("busy_len", bcnt, 2);
          chk("qx", 32'(qx), e.qx);
          chk("qy", 32'(qy), e.qy);
          chk("dx", 32'(dx), e.dx);
          chk("dy", 32'(dy), e.dy);
          chk("bounce_x_cnt", bxc, e.bx);
          chk("bounce_y_cnt", byc, e.by);
        end
        bcnt = 0; bxc = 0; byc = 0;
      end
      bprev = busy;
    end
  end
  task automatic mv_axis(inout int p, inout int d, output int b, input int mx, input int s);
    b = 0;
    if (s != 0) begin
      if (d != 0) begin
        if (p + s >= mx) begin p = mx; d = 0; b = 1; end
        else p += s;
      end else begin
        if (p <= s) begin p = 0; d = 1; b = 1; end
        else p -= s;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; sx = 10'd1; sy = 10'd0; step = 0;
    repeat (2) @(negedge clk);
    chk("rst_qx", 32'(qx), 220);
    chk("rst_qy", 32'(qy), 140);
    chk("rst_dx", 32'(dx), 1);
    chk("rst_dy", 32'(dy), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bounce", 32'({bounce_x, bounce_y, square}), 0);
    rst = 0;
    mqx = 220; mqy = 140; mdx = 1; mdy = 1; pend = 0;
  endtask
  // one frame: trigger cycle, then a mid-sequence speed glitch that must be ignored
  task automatic frame(input bit st_trig);
    exp_t e;
    int bx, by;
    logic [3:0] old;
    bit go;
    go = run || pend;
    @(negedge clk);
    sx = 10'd0; sy = 10'd480; step = st_trig;
    if (go) begin
      mv_axis(mqx, mdx, bx, 440, int'(speed));
      mv_axis(mqy, mdy, by, 280, int'(speed));
      e = '{mqx, mqy, mdx, mdy, bx, by};
      exp_q.push_back(e);
    end
    pend = run ? 0 : (go ? st_trig : (pend | st_trig));
    @(negedge clk);
    sx = 10'd1; sy = 10'd0; step = 0; old = speed; speed = 4'd9;
    @(negedge clk);
    speed = old;
    repeat (3) @(negedge clk);
  endtask
  task automatic step_pulse();
    @(negedge clk);
    sx = 10'd5; sy = 10'd7; step = 1;
    @(negedge clk);
    sx = 10'd1; sy = 10'd0; step = 0;
    pend = !run;
  endtask
  task automatic sq(input int x, input int y, input bit e);
    @(negedge clk);
    sx = 10'(x); sy = 10'(y); sq_v = 1;
    sq_q.push_back(e);
  endtask
  initial begin
    do_reset();
    run = 1; speed = 4'd2;
    frame(0);
    chk("free_qx", 32'(qx), 222);
    chk("free_qy", 32'(qy), 142);
    do_reset();
    speed = 4'd1;
    for (int f = 1; f <= 221; f++) begin
      frame(0);
      if (f == 140) begin chk("f140_qy", 32'(qy), 280); chk("f140_dy", 32'(dy), 0); end
      if (f == 220) begin chk("f220_qx", 32'(qx), 440); chk("f220_dx", 32'(dx), 0); end
    end
    chk("f221_qx", 32'(qx), 439);
    do_reset();
    speed = 4'd15;
    for (int f = 1; f <= 15; f++) begin
      frame(0);
      if (f == 9) chk("clamp_qy9", 32'(qy), 275);
      if (f == 10) chk("clamp_qy10", 32'(qy), 280);
      if (f == 14) chk("clamp_qx14", 32'(qx), 430);
    end
    chk("clamp_qx15", 32'(qx), 440);
    do_reset();
    run = 0; speed = 4'd3;
    frame(0);
    chk("idle_qx", 32'(qx), 220);
    step_pulse();
    frame(0);
    chk("step_qx", 32'(qx), 223);
    frame(0);
    chk("step_once_qx", 32'(qx), 223);
    frame(1);
    chk("step_coinc_qx", 32'(qx), 223);
    frame(0);
    chk("step_late_qx", 32'(qx), 226);
    frame(0);
    do_reset();
    for (int x = 215; x <= 425; x++) sq(x, 140, x >= 220 && x <= 419);
    sq(300, 339, 1);
    sq(300, 340, 0);
    sq(300, 139, 0);
    sq(219, 200, 0);
    @(negedge clk);
    sq_v = 0; sx = 10'd1; sy = 10'd0;
    repeat (4) @(negedge clk);
    chk("exp_q_left", exp_q.size(), 0);
    chk("sq_q_left", sq_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/square_mover.md
# square_mover

Per-frame motion controller for the on-screen square. It sits between the `simple_480p` display timing and the paint logic. Once per frame, during vertical blanking, it advances the square's top-left position (`qx`, `qy`) and bounces it off the screen edges. Every pixel clock it emits a registered `square` flag, so paint logic can colour the square without any geometry of its own.

## Interface
Parameters:
- `CORDW`, 10, screen coordinate width in bits.
- `H_RES`, 640, active horizontal pixels.
- `V_RES`, 480, active lines.
- `Q_SIZE`, 200, square side length in pixels; must be less than `V_RES`.

Ports (one clock; reset is synchronous and active-high):
- `clk_pix`  in  1  pixel clock; sole clock.
- `rst_pix`  in  1  synchronous, active-high reset.
- `sx`  in  CORDW  current horizontal screen position.
- `sy`  in  CORDW  current vertical screen position.
- `run`  in  1  level; 1 = move every frame.
- `step`  in  1  single-cycle pulse; request one move at the next frame while `run`=0.
- `speed`  in  4  pixels per move, per axis; sampled at the frame trigger.
- `qx`  out  CORDW  square left edge.
- `qy`  out  CORDW  square top edge.
- `dx`  out  1  horizontal direction; 1 = right.
- `dy`  out  1  vertical direction; 1 = down.
- `square`  out  1  registered; current pixel is inside the square.
- `busy`  out  1  update sequence in progress.
- `bounce_x`  out  1  one-cycle pulse when a horizontal edge is hit.
- `bounce_y`  out  1  one-cycle pulse when a vertical edge is hit.

## Operation
- Derived limits: X_MAX = `H_RES`-`Q_SIZE` (440); Y_MAX = `V_RES`-`Q_SIZE` (280).
- Frame trigger: `sx`==0 && `sy`==`V_RES`, i.e. the first blanking line. The trigger occurs once per frame.
- Step latch: `step`=1 sets `step_pend`. `step_pend` is cleared when a trigger is consumed, or whenever `run`=1.
- State machine, states IDLE, MOVE_X, MOVE_Y:
  - IDLE → MOVE_X on a trigger with (`run` || `step_pend`). At that trigger, latch `speed` into `spd` and clear `step_pend`.
  - A trigger with neither `run` nor `step_pend` stays in IDLE.
  - MOVE_X → MOVE_Y → IDLE unconditionally.
  - `busy` = (state != IDLE).
- MOVE_X arithmetic uses a CORDW+1-bit intermediate; no wrap-around is permitted.
  - Moving right (`dx`=1): if `qx`+`spd` >= X_MAX, then `qx`←X_MAX, `dx`←0, `bounce_x`←1. Otherwise `qx`←`qx`+`spd`.
  - Moving left (`dx`=0): if `qx` <= `spd`, then `qx`←0, `dx`←1, `bounce_x`←1. Otherwise `qx`←`qx`−`spd`.
- MOVE_Y: identical rules using `qy`, `dy`, Y_MAX and `bounce_y`.
- `spd`=0: position and direction are held and no bounce pulses fire; the state machine still sequences and `busy` still asserts.
- `square` is registered every cycle as (`sx`>=`qx` && `sx`<`qx`+`Q_SIZE` && `sy`>=`qy` && `sy`<`qy`+`Q_SIZE`).
  - The comparison uses CORDW+1 bits.
  - `square` is not gated by blanking; the consumer applies `de`.
- Position changes only during vertical blanking, so the square is tear-free.

## Timing
- Reset values, applied on the clock edge with `rst_pix`=1:
  - `qx`=X_MAX/2 (220), `qy`=Y_MAX/2 (140).
  - `dx`=1, `dy`=1.
  - `square`=0, `busy`=0, `bounce_x`=0, `bounce_y`=0.
  - state=IDLE, `step_pend`=0.
- Reset mid-sequence (in MOVE_X or MOVE_Y) aborts to the reset values; no partial move is kept.
- Trigger sampled in cycle T:
  - `busy`=1 in cycles T+1 and T+2.
  - `qx`, `dx` and `bounce_x` are updated at the end of T+1, so they are visible in T+2.
  - `qy`, `dy` and `bounce_y` are visible in T+3.
  - `busy`=0 from T+3.
- `bounce_x` and `bounce_y` are high for exactly one cycle each. A corner hit yields `bounce_x` at T+2 and `bounce_y` at T+3.
- `square` has 1-cycle latency from `sx`/`sy`.
- A `step` arriving in the same cycle as a trigger is not consumed by that trigger; it is held for the next frame.
- A `speed` change mid-frame has no effect until the next trigger.

## Test plan
- Reset: assert `rst_pix` for 2 cycles → `qx`=220, `qy`=140, `dx`=1, `dy`=1, all pulses and `busy` at 0.
- Free run: `run`=1, `speed`=2, run one frame → after T+3, `qx`=222, `qy`=142, `busy` high only for T+1 and T+2, no bounce pulses.
- Right and bottom bounce: `run`=1, `speed`=1 from reset.
  - Frame 140 → `qy`=280, `dy`=0, one `bounce_y` pulse.
  - Frame 220 → `qx`=440, `dx`=0, one `bounce_x` pulse.
  - Frame 221 → `qx`=439.
- Clamp: `speed`=15 from reset.
  - Move 15 → `qx`=440 with `bounce_x` (220+15·14 = 430, then 430+15 ≥ 440).
  - `qy` clamps to 280 on move 10.
  - No overflow past X_MAX or Y_MAX.
- Step: `run`=0, pulse `step` mid-frame → exactly one move at the next trigger, none at the following trigger.
  - `step` coincident with a trigger → the move happens one frame later.
- Square flag: from reset, sweep line `sy`=140.
  - `square`=1 one cycle after `sx`=220 through `sx`=419; 0 at `sx`=219 and `sx`=420.
  - Line `sy`=339 → flag present; line `sy`=340 → flag absent.
